// File: rtl/button_conditioner.sv
// Panel button front-end: synchronizes and debounces raw buttons, then turns each
// debounced level into press / long-press / release pulses plus the run/pause level.
module button_conditioner #(
  parameter int N_BTN       = 3,
  parameter int DEB_CYCLES  = 1000000,
  parameter int LONG_CYCLES = 100000000,
  parameter int CNT_W       = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             run_clear,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic             run_level
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } state_t;

  logic run_level_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             level_reg;
      logic [CNT_W-1:0] deb_cnt_reg;
      logic [CNT_W-1:0] hold_cnt_reg;
      state_t           state_reg;
      logic             press_reg;
      logic             long_reg;
      logic             release_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          level_reg    <= 1'b0;
          deb_cnt_reg  <= '0;
          hold_cnt_reg <= '0;
          state_reg    <= RELEASED;
          press_reg    <= 1'b0;
          long_reg     <= 1'b0;
          release_reg  <= 1'b0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;

          // Any return to the accepted level restarts the stability window.
          if (sync2_reg == level_reg) begin
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            level_reg   <= sync2_reg;
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + CNT_ONE;
          end

          press_reg   <= 1'b0;
          long_reg    <= 1'b0;
          release_reg <= 1'b0;

          // The FSM keeps tracking while disabled; only the pulses are gated.
          case (state_reg)
            RELEASED: begin
              if (level_reg) begin
                state_reg    <= PRESSED;
                hold_cnt_reg <= '0;
                press_reg    <= enable;
              end
            end
            PRESSED: begin
              if (!level_reg) begin
                state_reg   <= RELEASED;
                release_reg <= enable;
              end else if (hold_cnt_reg == LONG_LAST) begin
                state_reg <= HELD;
                long_reg  <= enable;
              end else begin
                hold_cnt_reg <= hold_cnt_reg + CNT_ONE;
              end
            end
            HELD: begin
              if (!level_reg) begin
                state_reg   <= RELEASED;
                release_reg <= enable;
              end
            end
            default: state_reg <= RELEASED;
          endcase
        end
      end

      assign btn_level[gi]     = level_reg;
      assign press_pulse[gi]   = press_reg;
      assign long_pulse[gi]    = long_reg;
      assign release_pulse[gi] = release_reg;
    end
  endgenerate

  // Toggles on the cycle the start/pause press pulse is visible, so a clear
  // raised alongside that pulse takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_level_reg <= 1'b0;
    end else if (!enable || run_clear) begin
      run_level_reg <= 1'b0;
    end else if (press_pulse[0]) begin
      run_level_reg <= ~run_level_reg;
    end
  end

  assign run_level = run_level_reg;

endmodule
